// File: rtl/usb_tx_packet_engine.sv
// USB full-speed transmit engine: SYNC, PID, payload, optional CRC16, bit stuffing, NRZI and EOP.
// Define USB_TX_CRC16_EN to append the CRC16 trailer to DATA packets.
module usb_tx_packet_engine #(
  parameter int DATA_WIDTH   = 16,
  parameter int MAX_WORDS    = 16,
  parameter int CLKS_PER_BIT = 8
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [DATA_WIDTH-1:0]          tx_data,
  input  logic [$clog2(MAX_WORDS+1)-1:0] word_count,
  input  logic                           transmit_start,
  input  logic                           transmit_empty,
  output logic                           read_enable,
  output logic                           d_plus_out,
  output logic                           d_minus_out,
  output logic                           busy,
  output logic                           tx_error
);
  localparam int WCW = $clog2(MAX_WORDS+1);
  localparam int BPW = DATA_WIDTH / 8;
  localparam int SW  = (DATA_WIDTH > 16) ? DATA_WIDTH : 16;
  localparam int LW  = $clog2(SW+1);
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam logic [WCW-1:0] MAX_WC   = WCW'(MAX_WORDS);
  localparam logic [CW-1:0]  LAST_CLK = CW'(CLKS_PER_BIT-1);

  typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC, EOP} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  clk_cnt;
  logic [SW-1:0]  shreg;
  logic [LW-1:0]  bits_left;
  logic [WCW-1:0] words_left;
  logic [7:0]     pid_reg;
  logic [2:0]     ones;
  logic [1:0]     eop_cnt;

  logic          tick, stuff_due, start_ok, err_set, capture;
  logic          shift, load, emit, emit_bit, data_bit, want_crc;
  logic [SW-1:0] load_val;
  logic [LW-1:0] load_len;
  logic [1:0]    line_next;
  logic [15:0]   crc_field;

  // Reordering bytes lets a whole word go out LSB-first: MS byte first, each byte LSB-first.
  function automatic logic [DATA_WIDTH-1:0] byte_rev(input logic [DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int j = 0; j < BPW; j++) r[8*j +: 8] = w[DATA_WIDTH-1-8*j -: 8];
    return r;
  endfunction

  assign tick      = (state != IDLE) && (clk_cnt == LAST_CLK);
  assign stuff_due = (ones == 3'd6);
  assign busy      = (state != IDLE);

  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    err_set    = 1'b0;
    capture    = 1'b0;
    shift      = 1'b0;
    load       = 1'b0;
    load_val   = '0;
    load_len   = '0;
    emit       = 1'b0;
    emit_bit   = 1'b0;
    data_bit   = 1'b0;
    case (state)
      IDLE: begin
        if (transmit_start) begin
          if ((tx_data[1:0] == 2'b11) && (word_count > MAX_WC)) begin
            err_set = 1'b1;
          end else begin
            start_ok   = 1'b1;
            load       = 1'b1;
            load_val   = SW'(8'h80);
            load_len   = LW'(8);
            state_next = SYNC;
          end
        end
      end
      SYNC, PID, DATA, CRC: begin
        // A field's first bit comes straight from its source at the boundary that starts it.
        if (tick) begin
          if (stuff_due) begin
            emit     = 1'b1;
            emit_bit = 1'b0;
          end else if (bits_left != '0) begin
            shift    = 1'b1;
            data_bit = (state == DATA);
          end else if (state == SYNC) begin
            load       = 1'b1;
            load_val   = SW'(pid_reg);
            load_len   = LW'(8);
            state_next = PID;
          end else if ((state == PID || state == DATA) && words_left != '0) begin
            if (transmit_empty) begin
              err_set    = 1'b1;
              state_next = EOP;
            end else begin
              capture    = 1'b1;
              load       = 1'b1;
              load_val   = SW'(byte_rev(tx_data));
              load_len   = LW'(DATA_WIDTH);
              data_bit   = 1'b1;
              state_next = DATA;
            end
          end else if (state != CRC && want_crc) begin
            load       = 1'b1;
            load_val   = SW'(crc_field);
            load_len   = LW'(16);
            state_next = CRC;
          end else begin
            state_next = EOP;
          end
        end
      end
      EOP: begin
        if (tick && eop_cnt == 2'd2) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (load) begin
      emit     = 1'b1;
      emit_bit = load_val[0];
    end else if (shift) begin
      emit     = 1'b1;
      emit_bit = shreg[0];
    end

    line_next = {d_plus_out, d_minus_out};
    if (emit && !emit_bit) line_next = ~line_next;
    if (state != EOP && state_next == EOP) line_next = 2'b00;
    if (state == EOP && tick && eop_cnt == 2'd1) line_next = 2'b10;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      clk_cnt     <= '0;
      shreg       <= '0;
      bits_left   <= '0;
      words_left  <= '0;
      pid_reg     <= '0;
      ones        <= '0;
      eop_cnt     <= '0;
      d_plus_out  <= 1'b1;
      d_minus_out <= 1'b0;
      read_enable <= 1'b0;
      tx_error    <= 1'b0;
    end else begin
      clk_cnt <= (state == IDLE || tick) ? '0 : clk_cnt + CW'(1);
      if (load) begin
        shreg     <= load_val >> 1;
        bits_left <= load_len - LW'(1);
      end else if (shift) begin
        shreg     <= shreg >> 1;
        bits_left <= bits_left - LW'(1);
      end
      if (start_ok) begin
        pid_reg    <= tx_data[7:0];
        words_left <= (tx_data[1:0] == 2'b11) ? word_count : '0;
      end else if (capture) begin
        words_left <= words_left - WCW'(1);
      end
      if (emit) ones <= emit_bit ? ones + 3'd1 : 3'd0;
      eop_cnt <= (state != EOP) ? 2'd0 : (tick ? eop_cnt + 2'd1 : eop_cnt);
      {d_plus_out, d_minus_out} <= line_next;
      read_enable <= start_ok | capture;
      if (start_ok)     tx_error <= 1'b0;
      else if (err_set) tx_error <= 1'b1;
    end
  end

`ifdef USB_TX_CRC16_EN
  // Reflected form of polynomial 0x8005, so the complemented register goes out LSB-first.
  logic [15:0] crc;
  logic        is_data;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc     <= 16'hFFFF;
      is_data <= 1'b0;
    end else if (start_ok) begin
      crc     <= 16'hFFFF;
      is_data <= (tx_data[1:0] == 2'b11);
    end else if (data_bit) begin
      crc <= {1'b0, crc[15:1]} ^ ((crc[0] ^ emit_bit) ? 16'hA001 : 16'h0000);
    end
  end

  assign want_crc  = is_data;
  assign crc_field = ~crc;
`else
  logic unused_crc;
  assign unused_crc = data_bit;
  assign want_crc   = 1'b0;
  assign crc_field  = 16'h0000;
`endif

endmodule

// File: tb/tb_usb_tx_packet_engine.sv
// Bench for usb_tx_packet_engine: directed and random packets against a bit-stream reference model.
module tb_usb_tx_packet_engine;
  localparam int DW  = 16;
  localparam int MW  = 16;
  localparam int CPB = 8;
  localparam int WCW = $clog2(MW+1);
  localparam logic [1:0] LJ  = 2'b10;
  localparam logic [1:0] LK  = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;
`ifdef USB_TX_CRC16_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           n_rst = 1'b1;
  logic [DW-1:0]  tx_data = '0;
  logic [WCW-1:0] word_count = '0;
  logic           transmit_start = 1'b0;
  logic           transmit_empty = 1'b0;
  logic           read_enable, d_plus_out, d_minus_out, busy, tx_error;

  int errors = 0;
  int checks = 0;
  int last_busy = 0;

  logic [1:0]    exp_q[$];
  int            bit_q[$];
  logic [DW-1:0] pay[MW];

  usb_tx_packet_engine #(.DATA_WIDTH(DW), .MAX_WORDS(MW), .CLKS_PER_BIT(CPB)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .tx_data        (tx_data),
    .word_count     (word_count),
    .transmit_start (transmit_start),
    .transmit_empty (transmit_empty),
    .read_enable    (read_enable),
    .d_plus_out     (d_plus_out),
    .d_minus_out    (d_minus_out),
    .busy           (busy),
    .tx_error       (tx_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) bit_q.push_back(int'(b[i]));
  endtask

  // Reference: raw bit stream -> stuffing -> NRZI line levels -> EOP.
  task automatic build_model(input logic [7:0] pid, input int nwords, input bit with_crc);
    logic [15:0] crc;
    logic [7:0]  bv;
    logic [1:0]  lvl;
    int          run;
    bit_q.delete();
    exp_q.delete();
    crc = 16'hFFFF;
    add_byte(8'h80);
    add_byte(pid);
    for (int w = 0; w < nwords; w++) begin
      for (int b = DW/8-1; b >= 0; b--) begin
        bv = pay[w][8*b +: 8];
        add_byte(bv);
        crc = crc ^ {8'h00, bv};
        for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
      end
    end
    if (with_crc) begin
      crc = ~crc;
      add_byte(crc[7:0]);
      add_byte(crc[15:8]);
    end
    lvl = LJ;
    run = 0;
    foreach (bit_q[i]) begin
      if (bit_q[i] == 0) lvl = (lvl == LJ) ? LK : LJ;
      exp_q.push_back(lvl);
      run = (bit_q[i] == 1) ? run + 1 : 0;
      if (run == 6) begin
        lvl = (lvl == LJ) ? LK : LJ;
        exp_q.push_back(lvl);
        run = 0;
      end
    end
    exp_q.push_back(SE0);
    exp_q.push_back(SE0);
    exp_q.push_back(LJ);
  endtask

  task automatic run_packet(input string tag, input logic [DW-1:0] hdr, input int wc,
                            input int under_idx, input int restart_cyc);
    bit is_data, under, exp_err;
    int nw, ncap, reads, busy_cyc, cyc, budget, exp_cycles;
    is_data = (hdr[1:0] == 2'b11);
    nw      = is_data ? wc : 0;
    under   = (under_idx >= 0) && (under_idx < nw);
    ncap    = under ? under_idx : nw;
    exp_err = under;
    build_model(hdr[7:0], ncap, CRC_ON && is_data && !under);
    exp_cycles = exp_q.size() * CPB;
    budget     = exp_cycles + 8 * CPB;
    tx_data        = hdr;
    word_count     = WCW'(wc);
    transmit_empty = 1'b0;
    transmit_start = 1'b1;
    @(posedge clk); #1;
    transmit_start = 1'b0;
    reads = 0;
    busy_cyc = 0;
    cyc = 1;
    while (busy === 1'b1 && cyc <= budget) begin
      transmit_start = (cyc == restart_cyc);
      busy_cyc++;
      if (cyc == 1) check({tag, " tx_error_cleared"}, 32'(tx_error), 32'(0));
      if (read_enable === 1'b1) begin
        if (reads < nw && reads == under_idx) begin
          transmit_empty = 1'b1;
        end else if (reads < nw) begin
          tx_data        = pay[reads];
          transmit_empty = 1'b0;
        end else begin
          tx_data = DW'($urandom);
        end
        reads++;
      end
      if ((cyc - 1) % CPB == 0 && exp_q.size() != 0)
        check($sformatf("%s line_bit%0d", tag, (cyc - 1) / CPB),
              32'({d_plus_out, d_minus_out}), 32'(exp_q.pop_front()));
      @(posedge clk); #1;
      cyc++;
    end
    transmit_start = 1'b0;
    transmit_empty = 1'b0;
    last_busy = busy_cyc;
    check({tag, " busy_cycles"}, 32'(busy_cyc), 32'(exp_cycles));
    check({tag, " bits_unsent"}, 32'(exp_q.size()), 32'(0));
    check({tag, " read_pulses"}, 32'(reads), 32'(ncap + 1));
    check({tag, " tx_error"}, 32'(tx_error), 32'(exp_err));
    check({tag, " idle_line"}, 32'({d_plus_out, d_minus_out}), 32'(LJ));
    if (busy !== 1'b0) begin
      n_rst = 1'b0; #1;
      n_rst = 1'b1;
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    int bad_j, wc, ui, pick;
    logic [7:0] pid;
    #2 n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset d_plus", 32'(d_plus_out), 32'(1));
    check("reset d_minus", 32'(d_minus_out), 32'(0));
    check("reset busy", 32'(busy), 32'(0));
    check("reset read_enable", 32'(read_enable), 32'(0));
    check("reset tx_error", 32'(tx_error), 32'(0));
    n_rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    run_packet("ack", 16'h80D2, 0, -1, 0);
    check("ack length", 32'(last_busy), 32'(152));

    run_packet("data0_zlp", 16'h80C3, 0, -1, 0);
    check("data0_zlp length", 32'(last_busy), 32'((CRC_ON ? 35 : 19) * CPB));

    pay[0] = 16'hFFFF;
    run_packet("stuff_ffff", 16'h00C3, 1, -1, 0);

    pay[0] = DW'($urandom);
    pay[1] = DW'($urandom);
    run_packet("underrun", 16'h004B, 2, 1, 0);
    repeat (3 * CPB) begin @(posedge clk); #1; end
    check("underrun tx_error_sticky", 32'(tx_error), 32'(1));

    tx_data        = 16'h80C3;
    word_count     = WCW'(17);
    transmit_start = 1'b1;
    @(posedge clk); #1;
    transmit_start = 1'b0;
    check("badlen tx_error", 32'(tx_error), 32'(1));
    check("badlen busy", 32'(busy), 32'(0));
    check("badlen read_enable", 32'(read_enable), 32'(0));
    bad_j = 0;
    repeat (3 * CPB) begin
      if ({d_plus_out, d_minus_out} !== LJ || busy !== 1'b0 || read_enable !== 1'b0) bad_j++;
      @(posedge clk); #1;
    end
    check("badlen line_stays_j", 32'(bad_j), 32'(0));

    for (int i = 0; i < 3; i++) pay[i] = DW'($urandom);
    run_packet("restart_busy", 16'h00C3, 3, -1, 11 * CPB);

    tx_data        = 16'h80D2;
    word_count     = '0;
    transmit_start = 1'b1;
    @(posedge clk); #1;
    transmit_start = 1'b0;
    repeat (11 * CPB) begin @(posedge clk); #1; end
    check("midpid busy", 32'(busy), 32'(1));
    n_rst = 1'b0;
    #1;
    check("midpid_reset line", 32'({d_plus_out, d_minus_out}), 32'(LJ));
    check("midpid_reset busy", 32'(busy), 32'(0));
    check("midpid_reset read_enable", 32'(read_enable), 32'(0));
    @(posedge clk); #1;
    n_rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    for (int p = 0; p < 6; p++) begin
      pick = $urandom_range(0, 3);
      case (pick)
        0:       pid = 8'hC3;
        1:       pid = 8'h4B;
        2:       pid = 8'hD2;
        default: pid = 8'($urandom);
      endcase
      wc = (pid[1:0] == 2'b11) ? $urandom_range(0, MW) : $urandom_range(0, 31);
      for (int i = 0; i < MW; i++) pay[i] = DW'($urandom);
      ui = -1;
      if (pid[1:0] == 2'b11 && wc > 0 && $urandom_range(0, 3) == 0) ui = $urandom_range(0, wc - 1);
      run_packet($sformatf("rand%0d", p), {8'($urandom), pid}, wc, ui, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
